// File: rtl/sram_arbiter.sv
// Round-robin arbiter and access sequencer sharing one async 8-bit SRAM
// between two requesters, with registered strobes and a one-cycle ack.
module sram_arbiter #(
    parameter int ADDR_WIDTH    = 18,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [7:0]            a_wdata,
    output logic [7:0]            a_rdata,
    output logic                  a_ack,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [7:0]            b_wdata,
    output logic [7:0]            b_rdata,
    output logic                  b_ack,
    output logic [ADDR_WIDTH-1:0] sramAddress,
    output logic [7:0]            sramDataOut,
    output logic                  sramDataOE,
    input  logic [7:0]            sramDataIn,
    output logic                  n_sRamCS,
    output logic                  n_sRamOE,
    output logic                  n_sRamWE,
    output logic                  owner
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t                  state, stateNext;
    logic [3:0]              cnt, cntNext;
    logic                    selB, selBNext;
    logic                    weLat, weLatNext;
    logic [ADDR_WIDTH-1:0]   addrNext;
    logic [7:0]              doutNext;
    logic                    csNext, oeNext, weNext, doeNext;
    logic                    ownerNext, aAckNext, bAckNext;
    logic [7:0]              aRdNext, bRdNext;
    logic                    pickB, pickWe;

    // On a tie the port that was not served last wins
    assign pickB  = b_req && (!a_req || !owner);
    assign pickWe = pickB ? b_we : a_we;

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        selBNext  = selB;
        weLatNext = weLat;
        addrNext  = sramAddress;
        doutNext  = sramDataOut;
        csNext    = n_sRamCS;
        oeNext    = n_sRamOE;
        weNext    = n_sRamWE;
        doeNext   = sramDataOE;
        ownerNext = owner;
        aAckNext  = 1'b0;
        bAckNext  = 1'b0;
        aRdNext   = a_rdata;
        bRdNext   = b_rdata;
        unique case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    stateNext = SETUP;
                    selBNext  = pickB;
                    ownerNext = pickB;
                    weLatNext = pickWe;
                    addrNext  = pickB ? b_addr : a_addr;
                    doutNext  = pickB ? b_wdata : a_wdata;
                    csNext    = 1'b0;
                    oeNext    = pickWe;
                    doeNext   = pickWe;
                end
            end
            SETUP: begin
                stateNext = ACCESS;
                cntNext   = CNT_LOAD;
                weNext    = !weLat;
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    stateNext = HOLD;
                    weNext    = 1'b1;
                    oeNext    = 1'b1;
                    aAckNext  = !selB;
                    bAckNext  = selB;
                    if (!weLat) begin
                        if (selB) bRdNext = sramDataIn;
                        else      aRdNext = sramDataIn;
                    end
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            HOLD: begin
                // Address and data stay driven one cycle past the WE rise
                stateNext = IDLE;
                csNext    = 1'b1;
                doeNext   = 1'b0;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            selB        <= 1'b0;
            weLat       <= 1'b0;
            sramAddress <= '0;
            sramDataOut <= 8'h00;
            n_sRamCS    <= 1'b1;
            n_sRamOE    <= 1'b1;
            n_sRamWE    <= 1'b1;
            sramDataOE  <= 1'b0;
            owner       <= 1'b1;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_rdata     <= 8'h00;
            b_rdata     <= 8'h00;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            selB        <= selBNext;
            weLat       <= weLatNext;
            sramAddress <= addrNext;
            sramDataOut <= doutNext;
            n_sRamCS    <= csNext;
            n_sRamOE    <= oeNext;
            n_sRamWE    <= weNext;
            sramDataOE  <= doeNext;
            owner       <= ownerNext;
            a_ack       <= aAckNext;
            b_ack       <= bAckNext;
            a_rdata     <= aRdNext;
            b_rdata     <= bRdNext;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed requests, per-port expected-ack queues
// drained by a negedge monitor, plus an ACCESS_CYCLES 1/15 timing sweep.
module tb_sram_arbiter;

    localparam int AW = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          n_reset;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [7:0]    a_wdata, b_wdata, a_rdata, b_rdata;
    logic          a_ack, b_ack;
    logic [AW-1:0] sramAddress;
    logic [7:0]    sramDataOut, sramDataIn;
    logic          sramDataOE, n_sRamCS, n_sRamOE, n_sRamWE, owner;

    logic [7:0] mem [0:(1<<AW)-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nChecks = 0;
    int nFail   = 0;

    typedef struct {
        int         ackCyc;
        logic [7:0] rdata;
    } exp_t;

    exp_t expA[$];
    exp_t expB[$];

    sram_arbiter #(.ADDR_WIDTH(AW), .ACCESS_CYCLES(2)) dut (
        .clk(clk), .n_reset(n_reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack),
        .sramAddress(sramAddress), .sramDataOut(sramDataOut),
        .sramDataOE(sramDataOE), .sramDataIn(sramDataIn),
        .n_sRamCS(n_sRamCS), .n_sRamOE(n_sRamOE), .n_sRamWE(n_sRamWE),
        .owner(owner)
    );

    // Sweep instances: ACCESS_CYCLES = 1 and 15
    logic          swReq = 1'b0;
    logic          swMeas = 1'b0;
    logic [7:0]    swRdA [2], swRdB [2], swDout [2];
    logic [AW-1:0] swAddr [2];
    logic          swDoe [2], swCs [2], swOe [2], swWe [2];
    logic          swAckA [2], swAckB [2], swOwner [2];
    int            weLow [2];
    int            ackAt [2];

    for (genvar g = 0; g < 2; g++) begin : gSweep
        sram_arbiter #(.ADDR_WIDTH(AW), .ACCESS_CYCLES(g == 0 ? 1 : 15)) sw (
            .clk(clk), .n_reset(n_reset),
            .a_req(swReq), .a_we(1'b1), .a_addr(18'h00055), .a_wdata(8'h99),
            .a_rdata(swRdA[g]), .a_ack(swAckA[g]),
            .b_req(1'b0), .b_we(1'b0), .b_addr(18'h00000), .b_wdata(8'h00),
            .b_rdata(swRdB[g]), .b_ack(swAckB[g]),
            .sramAddress(swAddr[g]), .sramDataOut(swDout[g]),
            .sramDataOE(swDoe[g]), .sramDataIn(8'h00),
            .n_sRamCS(swCs[g]), .n_sRamOE(swOe[g]), .n_sRamWE(swWe[g]),
            .owner(swOwner[g])
        );
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (swMeas) begin
                if (!swWe[i]) weLow[i] <= weLow[i] + 1;
                if (swAckA[i] && ackAt[i] < 0) ackAt[i] <= cyc;
            end else begin
                weLow[i] <= 0;
                ackAt[i] <= -1;
            end
        end
    end

    // SRAM model: combinational read, write while CS and WE are low
    always_comb sramDataIn = (!n_sRamCS && !n_sRamOE) ? mem[sramAddress] : 8'h00;

    initial begin
        mem[18'h01234] = 8'h5A;
        forever begin
            @(negedge clk);
            if (!n_sRamCS && !n_sRamWE) mem[sramAddress] = sramDataOut;
        end
    end

    function automatic void chk(string name, int act, int expv);
        nChecks++;
        if (act != expv) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            chk("oeOverlap", int'(sramDataOE && !n_sRamOE), 0);
            if (a_ack) begin
                if (expA.size() == 0) chk("unexpectedAckA", 1, 0);
                else begin
                    e = expA.pop_front();
                    chk("ackCycA", cyc, e.ackCyc);
                    chk("rdataA", a_rdata, e.rdata);
                    chk("ownerA", owner, 0);
                end
            end
            if (b_ack) begin
                if (expB.size() == 0) chk("unexpectedAckB", 1, 0);
                else begin
                    e = expB.pop_front();
                    chk("ackCycB", cyc, e.ackCyc);
                    chk("rdataB", b_rdata, e.rdata);
                    chk("ownerB", owner, 1);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL globalTimeout: still running at %0t, limit 100000", $time);
        $fatal(1);
    end

    // Issue one request; lat is the hand-computed cycles from now to ack.
    // With strobes set, the strobe pattern is checked for an immediate grant.
    task automatic doReq(input bit port, input bit we, input logic [AW-1:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rdExp,
                         input int lat, input bit strobes);
        exp_t x;
        int   k;
        bit   seen;
        x.ackCyc = cyc + lat;
        x.rdata  = rdExp;
        if (port) begin
            b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
            expB.push_back(x);
        end else begin
            a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
            expA.push_back(x);
        end
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            if (strobes) begin
                chk("csN", n_sRamCS, int'(!(k >= 1 && k <= 4)));
                chk("oeN", n_sRamOE, int'(!(!we && k >= 1 && k <= 3)));
                chk("weN", n_sRamWE, int'(!(we && k >= 2 && k <= 3)));
                chk("dataOE", sramDataOE, int'(we && k >= 1 && k <= 4));
                if (k >= 1 && k <= 4) begin
                    chk("addr", sramAddress, addr);
                    if (we) chk("wdata", sramDataOut, wdata);
                end
            end
            seen = port ? b_ack : a_ack;
            k++;
        end
        if (!seen) chk("ackTimeout", 0, 1);
        @(posedge clk); #1;
        if (port) b_req = 1'b0;
        else      a_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int c0;
        n_reset = 1'b0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rstCs", n_sRamCS, 1);
        chk("rstOe", n_sRamOE, 1);
        chk("rstWe", n_sRamWE, 1);
        chk("rstDoe", sramDataOE, 0);
        chk("rstAddr", sramAddress, 0);
        chk("rstDout", sramDataOut, 0);
        chk("rstAcks", {a_ack, b_ack}, 0);
        chk("rstRdata", {a_rdata, b_rdata}, 0);
        chk("rstOwner", owner, 1);
        @(posedge clk); #1;
        n_reset = 1'b1;
        @(posedge clk); #1;

        doReq(0, 0, 18'h01234, 8'h00, 8'h5A, 4, 1);
        doReq(1, 1, 18'h3FFFF, 8'hC3, 8'h00, 4, 1);
        chk("memWriteB", mem[18'h3FFFF], 8'hC3);
        doReq(0, 0, 18'h3FFFF, 8'h00, 8'hC3, 4, 1);

        // Reset during ACCESS of a write
        a_we = 1; a_addr = 18'h00100; a_wdata = 8'h77; a_req = 1;
        @(posedge clk); #1;
        a_req = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midWeLow", n_sRamWE, 0);
        n_reset = 1'b0;
        @(posedge clk); #1;
        n_reset = 1'b1;
        @(negedge clk);
        chk("midCs", n_sRamCS, 1);
        chk("midOe", n_sRamOE, 1);
        chk("midWe", n_sRamWE, 1);
        chk("midDoe", sramDataOE, 0);
        chk("midAck", a_ack, 0);
        chk("midAddr", sramAddress, 0);
        chk("midOwner", owner, 1);
        chk("midRdata", a_rdata, 0);
        repeat (4) @(posedge clk);
        #1;

        // Both requesting after reset: A, B, A, B
        fork
            begin
                doReq(0, 0, 18'h01234, 8'h00, 8'h5A, 4, 1);
                doReq(0, 1, 18'h00300, 8'h22, 8'h5A, 8, 0);
            end
            begin
                doReq(1, 1, 18'h00200, 8'h11, 8'h00, 9, 0);
                doReq(1, 0, 18'h00200, 8'h00, 8'h11, 8, 0);
            end
        join
        chk("memWriteA", mem[18'h00300], 8'h22);

        // B held from one cycle after A's grant; A re-requests
        fork
            begin
                doReq(0, 0, 18'h3FFFF, 8'h00, 8'hC3, 4, 1);
                doReq(0, 0, 18'h00300, 8'h00, 8'h22, 8, 0);
            end
            begin
                @(posedge clk); #1;
                doReq(1, 0, 18'h01234, 8'h00, 8'h5A, 8, 0);
            end
        join

        // Parameter sweep
        c0 = cyc;
        swReq = 1'b1;
        swMeas = 1'b1;
        @(posedge clk); #1;
        swReq = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        swMeas = 1'b0;
        chk("weWidth1", weLow[0], 1);
        chk("weWidth15", weLow[1], 15);
        chk("latency1", ackAt[0] - c0, 3);
        chk("latency15", ackAt[1] - c0, 17);

        repeat (3) @(posedge clk);
        chk("pendingA", expA.size(), 0);
        chk("pendingB", expB.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
